// File: rtl/fft_reorder_buf_pkg.sv
// fft_reorder_buf_pkg: shared defaults, read-FSM state encoding and bit-reverse helper
package fft_reorder_buf_pkg;
   localparam int N_DEF      = 16;
   localparam int POINTS_DEF = 8;
   localparam int LOG2P_DEF  = 3;
   typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} rd_state_t;
   function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < w; i++) r[i] = v[w-1-i];
      return r;
   endfunction
endpackage

// File: rtl/fft_reorder_buf_ram.sv
// fft_reorder_buf_ram: 2 x POINTS x N register array, one write port, asynchronous read port
module fft_reorder_buf_ram
   import fft_reorder_buf_pkg::*;
#(
   parameter int N      = N_DEF,
   parameter int POINTS = POINTS_DEF,
   parameter int LOG2P  = LOG2P_DEF
) (
   input  logic             clk,
   input  logic             we,
   input  logic             wr_bank,
   input  logic [LOG2P-1:0] wr_addr,
   input  logic [N-1:0]     wr_data,
   input  logic             rd_bank,
   input  logic [LOG2P-1:0] rd_addr,
   output logic [N-1:0]     rd_data
);
   logic [N-1:0] mem [2][POINTS];
   always_ff @(posedge clk)
      if (we) mem[wr_bank][wr_addr] <= wr_data;
   assign rd_data = mem[rd_bank][rd_addr];
endmodule

// File: rtl/fft_reorder_buf.sv
// fft_reorder_buf: ping-pong bit-reversed to natural-order reorder buffer with valid/ready output.
// Optional sticky drop flag port ovf when FFT_REORDER_OVF_EN is defined.
module fft_reorder_buf
   import fft_reorder_buf_pkg::*;
#(
   parameter int N      = N_DEF,
   parameter int POINTS = POINTS_DEF,
   parameter int LOG2P  = LOG2P_DEF
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         in_valid,
   input  logic [N-1:0] in_data,
   output logic         in_ready,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic         out_last
`ifdef FFT_REORDER_OVF_EN
   ,
   output logic         ovf
`endif
);
   localparam logic [LOG2P-1:0] LAST = LOG2P'(POINTS - 1);
   rd_state_t        state, state_nxt;
   logic [LOG2P-1:0] wr_cnt, rd_cnt, wr_addr;
   logic             wr_bank, rd_bank;
   logic [1:0]       bank_full;
   logic [N-1:0]     rd_data;
   logic             acc, rd_done;
   assign in_ready  = ~bank_full[wr_bank];
   assign acc       = in_valid & in_ready;
   assign wr_addr   = LOG2P'(bitrev(32'(wr_cnt), LOG2P));
   assign out_valid = state == DRAIN;
   assign rd_done   = out_valid & out_ready & (rd_cnt == LAST);
   assign out_data  = out_valid ? rd_data : '0;
   assign out_last  = out_valid & (rd_cnt == LAST);
   fft_reorder_buf_ram #(.N(N), .POINTS(POINTS), .LOG2P(LOG2P)) u_ram (
      .clk(clk), .we(acc), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(in_data),
      .rd_bank(rd_bank), .rd_addr(rd_cnt), .rd_data(rd_data)
   );
   always_ff @(posedge clk or posedge clear)
      if (clear) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      state_nxt = (state == IDLE) ? (bank_full[rd_bank] ? DRAIN : IDLE) : (rd_done ? IDLE : DRAIN);
   end
   // a write filling one bank and a read releasing the other bank may land on the same edge
   always_ff @(posedge clk or posedge clear)
      if (clear) begin
         wr_cnt    <= '0;
         rd_cnt    <= '0;
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b0;
         bank_full <= '0;
      end else begin
         if (acc) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_cnt == LAST) begin
               bank_full[wr_bank] <= 1'b1;
               wr_bank            <= ~wr_bank;
            end
         end
         if (state == IDLE) rd_cnt <= '0;
         else if (out_ready) rd_cnt <= rd_cnt + 1'b1;
         if (rd_done) begin
            bank_full[rd_bank] <= 1'b0;
            rd_bank            <= ~rd_bank;
         end
      end
`ifdef FFT_REORDER_OVF_EN
   always_ff @(posedge clk or posedge clear)
      if (clear) ovf <= 1'b0;
      else if (in_valid && !in_ready) ovf <= 1'b1;
`endif
endmodule

// File: tb/tb_fft_reorder_buf.sv
// tb_fft_reorder_buf: randomized scoreboard bench; frame-level reference model predicts accepts, drops and natural-order output
module tb_fft_reorder_buf;
   localparam int N = 16;
   localparam int P = 8;
   localparam int L = 3;
   logic         clk = 1'b0, clear = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
   logic [N-1:0] in_data = '0;
   logic         in_ready, out_valid, out_last;
   logic [N-1:0] out_data;
`ifdef FFT_REORDER_OVF_EN
   logic ovf;
`endif
   always #5 clk = ~clk;
   fft_reorder_buf dut (
      .clk(clk), .clear(clear), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
`ifdef FFT_REORDER_OVF_EN
      , .ovf(ovf)
`endif
   );
   typedef struct packed {logic [N-1:0] d; logic l;} exp_t;
   exp_t         exp_q[$];
   logic [N-1:0] part[P];
   int           k = 0, pushed = 0, popped = 0, leftover = 0;
   int           compared = 0, mismatched = 0;
   logic         exp_ready = 1'b1, exp_ovf = 1'b0, ovf_acc = 1'b0;
   logic         final_req = 1'b0, final_done = 1'b0;
   logic         prev_stall = 1'b0, prev_lastx = 1'b0, prev_l = 1'b0;
   logic [N-1:0] prev_d = '0;
   function automatic int brev(input int x);
      int r = 0;
      for (int i = 0; i < L; i++) r |= ((x >> i) & 1) << (L - 1 - i);
      return r;
   endfunction
   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      compared++;
      if (a !== e) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
      end
   endtask
   // reference model: a bank is free unless two frames are complete and not yet fully consumed
   task automatic step(input logic v, input logic [N-1:0] d, input logic r);
      @(posedge clk);
      #1;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      exp_ready = (pushed - popped) < 2;
      exp_ovf   = ovf_acc;
      if (v && !exp_ready) ovf_acc = 1'b1;
      if (v && exp_ready) begin
         part[brev(k)] = d;
         if (k == P - 1) begin
            for (int i = 0; i < P; i++) exp_q.push_back('{d: part[i], l: (i == P - 1)});
            pushed++;
            k = 0;
         end else k++;
      end
   endtask
   task automatic do_clear();
      @(posedge clk);
      #1;
      clear     = 1'b1;
      in_valid  = 1'b0;
      pushed    = 0;
      k         = 0;
      ovf_acc   = 1'b0;
      exp_ovf   = 1'b0;
      exp_ready = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
   endtask
   always @(negedge clk) begin
      if (clear) begin
         chk("rst_out_valid", out_valid, 0);
         chk("rst_out_data", out_data, 0);
         chk("rst_out_last", out_last, 0);
         chk("rst_in_ready", in_ready, 1);
`ifdef FFT_REORDER_OVF_EN
         chk("rst_ovf", ovf, 0);
`endif
         exp_q.delete();
         popped     = 0;
         prev_stall = 1'b0;
         prev_lastx = 1'b0;
      end else begin
         chk("in_ready", in_ready, exp_ready);
`ifdef FFT_REORDER_OVF_EN
         chk("ovf", ovf, exp_ovf);
`endif
         if (prev_lastx) chk("frame_gap", out_valid, 0);
         if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, prev_d);
            chk("hold_last", out_last, prev_l);
         end
         if (out_valid) begin
            if (exp_q.size() == 0) chk("unexpected_out", out_valid, 0);
            else begin
               chk("out_data", out_data, exp_q[0].d);
               chk("out_last", out_last, exp_q[0].l);
               if (out_ready) begin
                  if (exp_q[0].l) popped++;
                  void'(exp_q.pop_front());
               end
            end
         end else begin
            chk("idle_data", out_data, 0);
            chk("idle_last", out_last, 0);
         end
         prev_stall = out_valid && !out_ready;
         prev_lastx = out_valid && out_ready && out_last;
         prev_d     = out_data;
         prev_l     = out_last;
      end
      if (final_req && !final_done) begin
         chk("drain_leftover", leftover, 0);
         final_done = 1'b1;
      end
   end
   initial begin
      repeat (3) @(posedge clk);
      #1;
      clear = 1'b0;
      for (int i = 0; i < P; i++) step(1'b1, N'(brev(i) << 8), 1'b1);
      repeat (15) step(1'b0, '0, 1'b1);
      for (int i = 0; i < 3 * P; i++) step(1'b1, N'($urandom()), 1'b1);
      repeat (30) step(1'b0, '0, 1'b1);
      for (int i = 0; i < 3 * P; i++) step(1'b1, N'($urandom()), i >= 20);
      repeat (40) step(1'b0, '0, 1'b1);
      for (int i = 0; i < P; i++) step(1'b1, N'($urandom()), i[0]);
      for (int i = 0; i < 30; i++) step(1'b0, '0, i[0]);
      for (int i = 0; i < 5; i++) step(1'b1, N'($urandom()), 1'b1);
      do_clear();
      for (int i = 0; i < P; i++) step(1'b1, N'(16'h00A0 + 16'(brev(i))), 1'b1);
      repeat (20) step(1'b0, '0, 1'b1);
      for (int i = 0; i < 600; i++)
         step(1'($urandom_range(0, 3) != 0), N'($urandom()), 1'($urandom_range(0, 2) != 0));
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) step(1'b0, '0, 1'b1);
      leftover  = exp_q.size();
      final_req = 1'b1;
      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
